// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, byte-strobed RAM port between
// three read requesters (mm2s_0..2) and one write requester (s2mm).
// Round-robin arbitration with a bounded hold window of HOLD beats.
// Optional build macro ARB_WRITE_PRIORITY_EN: the write port preempts all
// reads and the hold window; owner, cnt and ptr are frozen while it does.
module mem_port_arbiter #(
   parameter int unsigned AXI_WIDTH = 128,
   parameter int unsigned ADDR_W    = 28,
   parameter int unsigned HOLD      = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [2:0]               rd_req,
   input  logic [2:0][ADDR_W-1:0]   rd_addr,
   output logic [2:0]               rd_gnt,
   output logic [2:0]               rd_rvalid,
   output logic [AXI_WIDTH-1:0]     rd_data,
   input  logic                     wr_req,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [AXI_WIDTH-1:0]     wr_data,
   input  logic [AXI_WIDTH/8-1:0]   wr_strb,
   output logic                     wr_gnt,
   output logic                     mem_ren,
   output logic                     mem_wen,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [AXI_WIDTH-1:0]     mem_wdata,
   output logic [AXI_WIDTH/8-1:0]   mem_strb,
   input  logic [AXI_WIDTH-1:0]     mem_rdata
);

   localparam int unsigned    CW     = $clog2(HOLD + 1);
   localparam logic [CW-1:0]  HOLD_C = CW'(HOLD);

   logic [3:0]    req;
   logic [1:0]    ptr;
   logic [1:0]    owner;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          hold_go;
   logic          arb_any;
   logic [1:0]    arb_idx;
   logic [1:0]    scan_idx;
   logic          preempt;
   logic [3:0]    gnt;

   assign req     = {wr_req, rd_req};
   assign hold_go = (cnt != '0) && req[owner] && (cnt < HOLD_C);

`ifdef ARB_WRITE_PRIORITY_EN
   assign preempt = rstn & wr_req;
`else
   assign preempt = 1'b0;
`endif

   // Pick the grantee: current owner inside its hold window, else first requester at/after ptr.
   always_comb begin
      arb_any  = 1'b0;
      arb_idx  = '0;
      scan_idx = '0;
      if (hold_go) begin
         arb_any = 1'b1;
         arb_idx = owner;
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (!arb_any && req[scan_idx]) begin
               arb_any = 1'b1;
               arb_idx = scan_idx;
            end
         end
      end
      if (!rstn) begin
         arb_any = 1'b0;
      end
   end

   // One-hot grant vector; a preempting write overrides the round-robin choice.
   always_comb begin
      gnt = '0;
      if (preempt) begin
         gnt[3] = 1'b1;
      end else if (arb_any) begin
         gnt[arb_idx] = 1'b1;
      end
   end

   assign rd_gnt  = gnt[2:0];
   assign wr_gnt  = gnt[3];
   assign cnt_nxt = (arb_idx == owner) ? cnt + 1'b1 : CW'(1);

   // RAM port mux: zero-latency from grant, address and strobes forced to 0 when not selected.
   always_comb begin
      mem_addr = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (gnt[i]) begin
            mem_addr = rd_addr[i];
         end
      end
      if (gnt[3]) begin
         mem_addr = wr_addr;
      end
   end

   assign mem_ren   = |gnt[2:0];
   assign mem_wen   = gnt[3];
   assign mem_wdata = wr_data;
   assign mem_strb  = gnt[3] ? wr_strb : '0;
   assign rd_data   = mem_rdata;

   // Hold-window bookkeeping and the one-cycle read-valid pipeline.
   // The owner-drop rule is applied first so that a same-cycle grant to a
   // new index still overrides cnt/owner, while ptr moves past the old owner.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr       <= '0;
         owner     <= '0;
         cnt       <= '0;
         rd_rvalid <= '0;
      end else begin
         rd_rvalid <= gnt[2:0];
         if (!preempt) begin
            if ((cnt != '0) && !req[owner]) begin
               ptr <= owner + 2'd1;
               cnt <= '0;
            end
            if (arb_any) begin
               owner <= arb_idx;
               if (cnt_nxt == HOLD_C) begin
                  ptr <= arb_idx + 2'd1;
                  cnt <= '0;
               end else begin
                  cnt <= cnt_nxt;
               end
            end else begin
               cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a write-first RAM model.
// Read results are scoreboarded: expected data is queued when a read grant is
// expected and compared when rd_rvalid is due one cycle later.
module tb_mem_port_arbiter;

   localparam int AW  = 128;
   localparam int ADW = 28;
   localparam int SW  = AW / 8;

   logic                clk = 1'b0;
   logic                rstn;
   logic [2:0]          rd_req;
   logic [2:0][ADW-1:0] rd_addr;
   logic [2:0]          rd_gnt;
   logic [2:0]          rd_rvalid;
   logic [AW-1:0]       rd_data;
   logic                wr_req;
   logic [ADW-1:0]      wr_addr;
   logic [AW-1:0]       wr_data;
   logic [SW-1:0]       wr_strb;
   logic                wr_gnt;
   logic                mem_ren;
   logic                mem_wen;
   logic [ADW-1:0]      mem_addr;
   logic [AW-1:0]       mem_wdata;
   logic [SW-1:0]       mem_strb;
   logic [AW-1:0]       mem_rdata;

   mem_port_arbiter #(.AXI_WIDTH(AW), .ADDR_W(ADW), .HOLD(4)) dut (
      .clk(clk), .rstn(rstn),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_rvalid(rd_rvalid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .wr_gnt(wr_gnt),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int            port;
      logic [AW-1:0] data;
      int            due;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   logic [AW-1:0] ref_mem [0:255];
   logic [AW-1:0] ram     [0:255];
   logic          ram_ready = 1'b0;
   logic [AW-1:0] ram_w;

   function automatic logic [AW-1:0] pat(input int i);
      return {32'(i), 32'hC0DE0000 ^ 32'(i), ~32'(i), 32'(i * 7 + 3)};
   endfunction

   task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Write-first single-port RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) ram[i] = pat(i);
         ram_ready = 1'b1;
      end
      if (mem_wen) begin
         ram_w = ram[mem_addr[7:0]];
         for (int b = 0; b < SW; b++)
            if (mem_strb[b]) ram_w[b*8 +: 8] = mem_wdata[b*8 +: 8];
         ram[mem_addr[7:0]] = ram_w;
      end
      if (mem_ren) mem_rdata <= ram[mem_addr[7:0]];
      cyc <= cyc + 1;
   end

   // Read-return monitor: rd_rvalid must match the queued expectation exactly when due.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
         chk("sb_due", AW'(sb[0].due), AW'(cyc));
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         mon_e = sb.pop_front();
         chk("rvalid", AW'(rd_rvalid), AW'(3'b001 << mon_e.port));
         chk("rdata", rd_data, mon_e.data);
      end else begin
         chk("rvalid_idle", AW'(rd_rvalid), '0);
      end
   end

   task automatic check_grant(input string tag, input logic [3:0] eg, input bit push);
      logic [ADW-1:0] ea;
      logic [SW-1:0]  es;
      ea = '0;
      es = '0;
      for (int i = 0; i < 3; i++) if (eg[i]) ea = rd_addr[i];
      if (eg[3]) begin
         ea = wr_addr;
         es = wr_strb;
      end
      chk({tag, "_gnt"},  AW'({wr_gnt, rd_gnt}), AW'(eg));
      chk({tag, "_ren"},  AW'(mem_ren), AW'(|eg[2:0]));
      chk({tag, "_wen"},  AW'(mem_wen), AW'(eg[3]));
      chk({tag, "_addr"}, AW'(mem_addr), AW'(ea));
      chk({tag, "_strb"}, AW'(mem_strb), AW'(es));
      if (eg[3]) begin
         chk({tag, "_wdata"}, mem_wdata, wr_data);
         for (int b = 0; b < SW; b++)
            if (wr_strb[b]) ref_mem[wr_addr[7:0]][b*8 +: 8] = wr_data[b*8 +: 8];
      end
      if (push)
         for (int i = 0; i < 3; i++)
            if (eg[i]) sb.push_back('{port: i, data: ref_mem[rd_addr[i][7:0]], due: cyc + 1});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn   = 1'b0;
      rd_req = '0;
      wr_req = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_grant("rst", 4'b0000, 1'b1);
         next_cycle();
      end
      rstn = 1'b1;
   endtask

   task automatic idle(input int n);
      rd_req = '0;
      wr_req = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         check_grant("idle", 4'b0000, 1'b1);
         next_cycle();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      rstn    = 1'b0;
      rd_req  = '0;
      rd_addr = '0;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_strb = '0;

      // Reset with all requests low.
      do_reset();

      // Round robin across three reads with HOLD=4 bursts.
      rd_addr[0] = 28'h40;
      rd_addr[1] = 28'h41;
      rd_addr[2] = 28'h42;
      rd_req     = 3'b111;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         check_grant("rr3", 4'b0001 << ((c / 4) % 3), 1'b1);
         next_cycle();
      end
      idle(2);

      // Single one-cycle read on port 1.
      do_reset();
      rd_addr[1] = 28'h10;
      rd_req     = 3'b010;
      @(negedge clk);
      check_grant("single1", 4'b0010, 1'b1);
      next_cycle();
      idle(2);

      // Byte-strobed write followed immediately by a read of the same word.
      do_reset();
      wr_req  = 1'b1;
      wr_addr = 28'h20;
      wr_data = {16{8'hA5}};
      wr_strb = 16'h000F;
      @(negedge clk);
      check_grant("wr", 4'b1000, 1'b1);
      next_cycle();
      wr_req     = 1'b0;
      rd_addr[0] = 28'h20;
      rd_req     = 3'b001;
      @(negedge clk);
      check_grant("raw", 4'b0001, 1'b1);
      next_cycle();
      idle(2);

      // All four requesters held constant.
      do_reset();
      rd_addr[0] = 28'h40;
      rd_addr[1] = 28'h41;
      rd_addr[2] = 28'h42;
      wr_addr    = 28'h30;
      wr_data    = {4{32'h1234_5678}};
      wr_strb    = '1;
      rd_req     = 3'b111;
      wr_req     = 1'b1;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
`ifdef ARB_WRITE_PRIORITY_EN
         check_grant("all4", 4'b1000, 1'b1);
`else
         check_grant("all4", 4'b0001 << ((c / 4) % 4), 1'b1);
`endif
         next_cycle();
      end
      idle(2);

      // Reset during a port-2 hold at cnt=2 drops the pending read return.
      do_reset();
      rd_addr[2] = 28'h42;
      rd_req     = 3'b100;
      @(negedge clk);
      check_grant("hold2a", 4'b0100, 1'b1);
      next_cycle();
      @(negedge clk);
      check_grant("hold2b", 4'b0100, 1'b0);
      rstn = 1'b0;
      next_cycle();
      @(negedge clk);
      check_grant("midrst", 4'b0000, 1'b1);
      next_cycle();
      rstn   = 1'b1;
      rd_req = 3'b111;
      rd_addr[0] = 28'h05;
      @(negedge clk);
      check_grant("post_rst", 4'b0001, 1'b1);
      next_cycle();
      @(negedge clk);
      check_grant("post_rst2", 4'b0001, 1'b1);
      next_cycle();
      idle(2);

      chk("sb_empty", AW'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, byte-strobed RAM port between the three read requesters (mm2s_0, mm2s_1, mm2s_2) and the one write requester (s2mm) of the systolic-array memory path. Arbitration is round-robin with a bounded hold window, so a streaming requester keeps consecutive RAM beats up to a limit. The block sits between the DMA engines and the RAM model or BRAM. Without it, each engine needs a private memory port.

## Interface
- `AXI_WIDTH`, 128: data width of every port, bits.
- `ADDR_W`, 28: word-address width (AXI_ADDR_WIDTH-LSB).
- `HOLD`, 4: maximum consecutive grants to one requester (≥1).

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rstn` in 1: reset, synchronous, active-low.
- `rd_req` in 3: read request per port; index i = mm2s_i.
- `rd_addr` in 3×ADDR_W: word address per read port.
- `rd_gnt` out 3: one-hot read grant.
- `rd_rvalid` out 3: registered; `rd_data` valid for port i.
- `rd_data` out AXI_WIDTH: shared read data bus (= `mem_rdata`).
- `wr_req` in 1: write request, s2mm.
- `wr_addr` in ADDR_W: write word address.
- `wr_data` in AXI_WIDTH: write data.
- `wr_strb` in AXI_WIDTH/8: byte strobes.
- `wr_gnt` out 1: write grant.
- `mem_ren` out 1: RAM read enable.
- `mem_wen` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out AXI_WIDTH: RAM write data.
- `mem_strb` out AXI_WIDTH/8: RAM strobes.
- `mem_rdata` in AXI_WIDTH: RAM read data, one cycle after `mem_ren`.

## Operation
- Requester index 0..2 is rd port 0..2; index 3 is wr. `req[3:0] = {wr_req, rd_req}`.
- A requester holds req and its address, data and strobes stable until granted in that cycle. A single grant transfers one beat.
- **Grant is combinational** from req, `ptr` (2-bit) and the hold state.
  - At most one grant bit is set per cycle.
  - The grantee is the first requesting index at or after `ptr`, wrapping 3→0.
- **Hold:** `owner` (2-bit) and `cnt` (0..HOLD) are registers.
  - If `cnt>0` and `req[owner]` is high and `cnt<HOLD`, grant `owner` regardless of ptr.
  - On a grant to the same `owner`, `cnt` increments.
  - On a grant to a new index, `owner` takes that index and `cnt` becomes 1.
  - On a cycle with no grant, `cnt` becomes 0.
  - When a grant takes `cnt` to HOLD, `ptr` takes owner+1 (mod 4) and `cnt` becomes 0.
  - When the owner drops req, `ptr` takes owner+1 and `cnt` becomes 0.
- **RAM mux:**
  - `mem_ren = |rd_gnt`; `mem_wen = wr_gnt`.
  - `mem_addr` comes from the granted index, or 0 when idle.
  - `mem_wdata` and `mem_strb` pass `wr_data` and `wr_strb`. `mem_strb` is 0 unless `wr_gnt`.
- **Read return:**
  - `rd_rvalid` is `rd_gnt` delayed one cycle.
  - `rd_data` is `mem_rdata`, unregistered.
- Reset values while `rstn=0`: all grants 0, `mem_ren=0`, `mem_wen=0`, `rd_rvalid=0`, `ptr=0`, `cnt=0`, `owner=0`.
- Reset mid-burst drops every pending `rd_rvalid`.

## Timing
- Grant-to-RAM latency: 0 cycles. Grant-to-rvalid latency: 1 cycle.
- Throughput: 1 beat per cycle in aggregate.
- Worst-case wait for a continuously requesting port: 3·HOLD cycles.
- Read-after-write to the same address in consecutive cycles returns the new data. This relies on RAM write-first semantics and holds because the block never grants both in one cycle.
- A `req` deasserted by the requester in the same cycle as the last `cnt` increment follows the owner-drop rule in the next cycle.

## Configuration
- `ARB_WRITE_PRIORITY_EN` defined:
  - `wr_req` preempts all reads and the hold window; `wr_gnt` is asserted whenever `wr_req=1`.
  - `owner` and `cnt` are unchanged during preemption.
  - Holding writes stall read ports indefinitely; this is accepted.
- Undefined: the write port is index 3 in the plain round-robin.

## Test plan
- Reset, all req=0 → every grant 0, `mem_ren=0`, `mem_wen=0`, `rd_rvalid=0` for 5 cycles.
- `rd_req=3'b111` held, HOLD=4 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0… `rd_rvalid` matches each grant one cycle later. `rd_data` equals the RAM word at `rd_addr` of the granted port.
- `rd_req[1]` only, addr 0x10, one cycle → `rd_gnt=3'b010`, `mem_addr=0x10`. Next cycle `rd_rvalid=3'b010`.
- `wr_req` with strb=0x000F, addr 0x20, data 0xA5…; then read 0x20 on port 0 → bytes 0–3 return 0xA5, other bytes unchanged.
- All 4 req constant, no macro → every index granted at least once in every 16-cycle window. With `ARB_WRITE_PRIORITY_EN` → `wr_gnt=1` on every cycle.
- `rstn` low during a port-2 hold (cnt=2) → next cycle all outputs 0. After release, port 0 wins first.
